// File: rtl/mpu6050_regs_pkg.sv
// rtl/mpu6050_regs_pkg.sv - register map constants and FSM encoding for the MPU6050 I2C responder
//
// Purpose: shared register addresses, the PWR_MGMT_1 reset value and the
// responder FSM state type. No ports.

package mpu6050_regs_pkg;

  localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] REG_ACCEL_ZOUT_L = 8'h40;
  localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] REG_WHO_AM_I     = 8'h75;
  localparam logic [7:0] PWR_MGMT_1_RESET = 8'h40;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    REG,
    ACK_REG,
    WDATA,
    ACK_WDATA,
    RDATA,
    RACK
  } i2c_state_e;

  // True when the pointer falls inside the six accelerometer snapshot bytes.
  function automatic logic is_accel_reg(input logic [7:0] ptr);
    return (ptr >= REG_ACCEL_XOUT_H) && (ptr <= REG_ACCEL_ZOUT_L);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizer with START, STOP and SCL edge detection
//
// Purpose: brings the asynchronous bus levels into the clk domain and flags
// bus events as single-cycle pulses.
// Ports:
//   clk, rst       system clock, asynchronous active-low reset
//   scl_i, sda_i   raw bus levels
//   sda            synchronized SDA level
//   scl_rise       synchronized SCL 0->1 pulse
//   scl_fall       synchronized SCL 1->0 pulse
//   start_det      SDA 1->0 while SCL high
//   stop_det       SDA 0->1 while SCL high

module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_q;
  logic       sda_q;
  logic [1:0] prime_cnt;
  logic       armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_ff    <= 2'b11;
      sda_ff    <= 2'b11;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      prime_cnt <= 2'd0;
    end else begin
      scl_ff <= {scl_ff[0], scl_i};
      sda_ff <= {sda_ff[0], sda_i};
      scl_q  <= scl_ff[1];
      sda_q  <= sda_ff[1];
      if (prime_cnt != 2'd3) begin
        prime_cnt <= prime_cnt + 2'd1;
      end
    end
  end

  // Events are suppressed until the pipeline holds only real bus samples;
  // otherwise the forced-high reset values could fake a START when reset is
  // released while a master holds SDA low.
  assign armed = (prime_cnt == 2'd3);

  assign sda       = sda_ff[1];
  assign scl_rise  = armed &  scl_ff[1] & ~scl_q;
  assign scl_fall  = armed & ~scl_ff[1] &  scl_q;
  assign start_det = armed &  scl_ff[1] &  scl_q & sda_q  & ~sda_ff[1];
  assign stop_det  = armed &  scl_ff[1] &  scl_q & ~sda_q &  sda_ff[1];

endmodule

// File: rtl/mpu6050_i2c_responder.sv
// rtl/mpu6050_i2c_responder.sv - I2C target emulating the MPU6050 register interface
//
// Purpose: answers at DEV_ADDR, keeps a register pointer, stores PWR_MGMT_1,
// serves WHO_AM_I and a coherent accelerometer snapshot, everything else reads 0.
// Ports:
//   clk, rst              system clock, asynchronous active-low reset
//   scl_i, sda_i          bus levels (asynchronous)
//   sda_drive_low         1 pulls SDA low (open drain), 0 releases
//   accel_x/y/z           live accelerometer samples
//   pwr_mgmt              current PWR_MGMT_1 value
//   busy                  addressed and transaction in progress

module mpu6050_i2c_responder
  import mpu6050_regs_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR     = 7'h68,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_drive_low,
  input  logic [15:0] accel_x,
  input  logic [15:0] accel_y,
  input  logic [15:0] accel_z,
  output logic [7:0]  pwr_mgmt,
  output logic        busy
);

  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e  state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  tx, tx_n;
  logic        rw, rw_n;
  logic [7:0]  reg_ptr, ptr_n;
  logic [7:0]  pwr_q, pwr_n;
  logic        busy_q, busy_n;
  logic        drive_q, drive_n;
  logic [47:0] snap, snap_n;
  logic [7:0]  rd_byte;
  logic [7:0]  acc_off;

  // Read data for the current pointer.
  always_comb begin
    rd_byte = 8'h00;
    acc_off = reg_ptr - REG_ACCEL_XOUT_H;
    if (reg_ptr == REG_WHO_AM_I) begin
      rd_byte = WHO_AM_I_VAL;
    end else if (reg_ptr == REG_PWR_MGMT_1) begin
      rd_byte = pwr_q;
    end else if (is_accel_reg(reg_ptr)) begin
      case (acc_off)
        8'd0:    rd_byte = snap[47:40];
        8'd1:    rd_byte = snap[39:32];
        8'd2:    rd_byte = snap[31:24];
        8'd3:    rd_byte = snap[23:16];
        8'd4:    rd_byte = snap[15:8];
        default: rd_byte = snap[7:0];
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    tx_n      = tx;
    rw_n      = rw;
    ptr_n     = reg_ptr;
    pwr_n     = pwr_q;
    busy_n    = busy_q;
    drive_n   = drive_q;
    snap_n    = snap;

    if (start_det) begin
      // Also covers a repeated START in the middle of a byte.
      state_n   = ADDR;
      bit_cnt_n = 4'd0;
      drive_n   = 1'b0;
    end else if (stop_det) begin
      state_n = IDLE;
      drive_n = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
        end

        ADDR: begin
          if (scl_rise) begin
            shreg_n   = {shreg[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (shreg[7:1] == DEV_ADDR) begin
              state_n = ACK_ADDR;
              drive_n = 1'b1;
              busy_n  = 1'b1;
              rw_n    = shreg[0];
              // Freeze all six bytes once per read so a burst is coherent.
              if (shreg[0]) begin
                snap_n = {accel_x, accel_y, accel_z};
              end
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end
        end

        ACK_ADDR: begin
          if (scl_fall) begin
            bit_cnt_n = 4'd0;
            if (rw) begin
              state_n = RDATA;
              tx_n    = rd_byte;
              drive_n = ~rd_byte[7];
            end else begin
              state_n = REG;
              drive_n = 1'b0;
            end
          end
        end

        REG: begin
          if (scl_rise) begin
            shreg_n   = {shreg[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            ptr_n   = shreg;
            state_n = ACK_REG;
            drive_n = 1'b1;
          end
        end

        ACK_REG, ACK_WDATA: begin
          if (scl_fall) begin
            state_n   = WDATA;
            drive_n   = 1'b0;
            bit_cnt_n = 4'd0;
          end
        end

        WDATA: begin
          if (scl_rise) begin
            shreg_n   = {shreg[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (reg_ptr == REG_PWR_MGMT_1) begin
              pwr_n = shreg;
            end
            ptr_n   = reg_ptr + 8'd1;
            state_n = ACK_WDATA;
            drive_n = 1'b1;
          end
        end

        RDATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_n = RACK;
              drive_n = 1'b0;
              ptr_n   = reg_ptr + 8'd1;
            end else begin
              tx_n    = {tx[6:0], 1'b0};
              drive_n = ~tx[6];
            end
          end
        end

        RACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end else if (scl_fall) begin
            // Pointer was already advanced when the previous byte finished.
            state_n   = RDATA;
            tx_n      = rd_byte;
            drive_n   = ~rd_byte[7];
            bit_cnt_n = 4'd0;
          end
        end

        default: begin
          state_n = IDLE;
          drive_n = 1'b0;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      shreg   <= 8'h00;
      tx      <= 8'h00;
      rw      <= 1'b0;
      reg_ptr <= 8'h00;
      pwr_q   <= PWR_MGMT_1_RESET;
      busy_q  <= 1'b0;
      drive_q <= 1'b0;
      snap    <= 48'h0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
      rw      <= rw_n;
      reg_ptr <= ptr_n;
      pwr_q   <= pwr_n;
      busy_q  <= busy_n;
      drive_q <= drive_n;
      snap    <= snap_n;
    end
  end

  assign sda_drive_low = drive_q;
  assign busy          = busy_q;
  assign pwr_mgmt      = pwr_q;

endmodule

// File: tb/tb_mpu6050_i2c_responder.sv
// tb/tb_mpu6050_i2c_responder.sv - closed-loop bit-banged master bench for mpu6050_i2c_responder

module tb_mpu6050_i2c_responder;

  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m_low = 1'b0;
  logic [15:0] ax = 16'h0000;
  logic [15:0] ay = 16'h0000;
  logic [15:0] az = 16'h0000;
  logic        sda_drive_low;
  logic [7:0]  pwr_mgmt;
  logic        busy;

  // Pull-up on SDA: low when either side pulls it down.
  wire sda_line = ~(sda_m_low | sda_drive_low);

  always #5 clk = ~clk;

  mpu6050_i2c_responder dut (
    .clk           (clk),
    .rst           (rst),
    .scl_i         (scl_m),
    .sda_i         (sda_line),
    .sda_drive_low (sda_drive_low),
    .accel_x       (ax),
    .accel_y       (ay),
    .accel_z       (az),
    .pwr_mgmt      (pwr_mgmt),
    .busy          (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int drive_cnt = 0;
  int busy_cnt  = 0;

  always @(negedge clk) begin
    if (sda_drive_low) drive_cnt++;
    if (busy) busy_cnt++;
  end

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [15:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 16'(sb.size()), 16'd1);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic qw;
    repeat (Q) @(posedge clk);
  endtask

  task automatic start_cond;
    sda_m_low = 1'b0; qw;
    scl_m = 1'b1;     qw;
    sda_m_low = 1'b1; qw;
    scl_m = 1'b0;     qw;
  endtask

  task automatic stop_cond;
    sda_m_low = 1'b1; qw;
    scl_m = 1'b1;     qw;
    sda_m_low = 1'b0; qw;
    qw;
  endtask

  task automatic send_bit(input logic b);
    sda_m_low = ~b; qw;
    scl_m = 1'b1;   qw;
    qw;
    scl_m = 1'b0;   qw;
  endtask

  task automatic recv_bit(output logic b);
    sda_m_low = 1'b0; qw;
    scl_m = 1'b1;     qw;
    @(negedge clk);
    b = sda_line;
    qw;
    scl_m = 1'b0;     qw;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string tag);
    logic a;
    sb_push(tag, 16'(exp_ack));
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(a);
    sb_pop(16'(a));
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic nack, input string tag);
    logic [7:0] d;
    sb_push(tag, 16'(exp));
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    send_bit(nack);
    sb_pop(16'(d));
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc0, bc0;
    logic a;

    // Reset state
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_sda", 16'(sda_drive_low), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_pwr", 16'(pwr_mgmt), 16'h40);
    check("rst_ptr", 16'(dut.reg_ptr), 16'h00);
    rst = 1'b1;
    qw;

    // WHO_AM_I through repeated START
    start_cond;
    write_byte(8'hD0, 1'b0, "who_addr_w_ack");
    check("who_busy_mid", 16'(busy), 16'd1);
    write_byte(8'h75, 1'b0, "who_reg_ack");
    start_cond;
    write_byte(8'hD1, 1'b0, "who_addr_r_ack");
    read_byte(8'h68, 1'b1, "who_data");
    stop_cond;
    @(negedge clk);
    check("who_busy_after", 16'(busy), 16'd0);

    // PWR_MGMT_1 write and read back
    start_cond;
    write_byte(8'hD0, 1'b0, "pwr_addr_ack");
    write_byte(8'h6B, 1'b0, "pwr_reg_ack");
    write_byte(8'h00, 1'b0, "pwr_data_ack");
    stop_cond;
    check("pwr_value", 16'(pwr_mgmt), 16'h00);
    start_cond;
    write_byte(8'hD0, 1'b0, "pwr_rb_addr_ack");
    write_byte(8'h6B, 1'b0, "pwr_rb_reg_ack");
    start_cond;
    write_byte(8'hD1, 1'b0, "pwr_rb_addr_r_ack");
    read_byte(8'h00, 1'b1, "pwr_rb_data");
    stop_cond;

    // Coherent accel burst; live inputs change after the first byte
    ax = 16'h1234; ay = 16'hABCD; az = 16'h0001;
    start_cond;
    write_byte(8'hD0, 1'b0, "acc_addr_ack");
    write_byte(8'h3B, 1'b0, "acc_reg_ack");
    start_cond;
    write_byte(8'hD1, 1'b0, "acc_addr_r_ack");
    read_byte(8'h12, 1'b0, "acc_b0");
    ax = 16'hFFFF; ay = 16'h5555; az = 16'h7777;
    read_byte(8'h34, 1'b0, "acc_b1");
    read_byte(8'hAB, 1'b0, "acc_b2");
    read_byte(8'hCD, 1'b0, "acc_b3");
    read_byte(8'h00, 1'b0, "acc_b4");
    read_byte(8'h01, 1'b1, "acc_b5");
    stop_cond;

    // Foreign address: no ACK, no drive, no busy, no write
    dc0 = drive_cnt;
    bc0 = busy_cnt;
    start_cond;
    write_byte(8'hA0, 1'b1, "foreign_addr_nack");
    write_byte(8'h6B, 1'b1, "foreign_reg_nack");
    write_byte(8'h55, 1'b1, "foreign_data_nack");
    stop_cond;
    check("foreign_drive", 16'(drive_cnt - dc0), 16'd0);
    check("foreign_busy", 16'(busy_cnt - bc0), 16'd0);
    check("foreign_pwr", 16'(pwr_mgmt), 16'h00);

    // Pointer wrap
    start_cond;
    write_byte(8'hD0, 1'b0, "wrap_addr_ack");
    write_byte(8'hFF, 1'b0, "wrap_reg_ack");
    start_cond;
    write_byte(8'hD1, 1'b0, "wrap_addr_r_ack");
    read_byte(8'h00, 1'b0, "wrap_b_ff");
    read_byte(8'h00, 1'b1, "wrap_b_00");
    stop_cond;
    check("wrap_ptr", 16'(dut.reg_ptr), 16'h01);

    // Burst write: 0x6A discarded, 0x6B stored via auto-increment
    start_cond;
    write_byte(8'hD0, 1'b0, "bw_addr_ack");
    write_byte(8'h6A, 1'b0, "bw_reg_ack");
    write_byte(8'h77, 1'b0, "bw_d0_ack");
    write_byte(8'h81, 1'b0, "bw_d1_ack");
    stop_cond;
    check("bw_pwr", 16'(pwr_mgmt), 16'h81);
    check("bw_ptr", 16'(dut.reg_ptr), 16'h6C);

    // Reset during bit 4 of a data byte (0xAA, bit 4 is 0)
    start_cond;
    write_byte(8'hD0, 1'b0, "mr_addr_ack");
    write_byte(8'h6B, 1'b0, "mr_reg_ack");
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    sda_m_low = 1'b1; qw;
    scl_m = 1'b1;     qw;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mr_sda", 16'(sda_drive_low), 16'd0);
    check("mr_pwr", 16'(pwr_mgmt), 16'h40);
    check("mr_busy", 16'(busy), 16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    dc0 = drive_cnt;
    qw;
    scl_m = 1'b0; qw;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    sb_push("mr_tail_nack", 16'd1);
    recv_bit(a);
    sb_pop(16'(a));
    stop_cond;
    check("mr_tail_drive", 16'(drive_cnt - dc0), 16'd0);
    check("mr_tail_pwr", 16'(pwr_mgmt), 16'h40);

    start_cond;
    write_byte(8'hD0, 1'b0, "mr_next_addr_ack");
    write_byte(8'h75, 1'b0, "mr_next_reg_ack");
    start_cond;
    write_byte(8'hD1, 1'b0, "mr_next_addr_r_ack");
    read_byte(8'h68, 1'b1, "mr_next_data");
    stop_cond;

    check("sb_drained", 16'(sb.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
